// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared pc_sel encodings, fetch FSM states and reset PC for the fetch stage
package fetch_pkg;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
  localparam logic [1:0] PC_SEL_RSVD   = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_e;

  // A redirect only counts when it names a real target source
  function automatic logic redirect_taken(input logic redirect, input logic [1:0] sel);
    return redirect && ((sel == PC_SEL_BRANCH) || (sel == PC_SEL_JUMP));
  endfunction

endpackage

// File: rtl/npc_sel_mux.sv
// rtl/npc_sel_mux.sv - combinational next-PC selector over pc+4, branch and jump targets
module npc_sel_mux
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] branch_tgt,
  input  logic [XLEN-1:0] jump_tgt,
  output logic [XLEN-1:0] npc
);

  // Reserved encoding falls back to the sequential path
  always_comb begin
    npc = pc_plus4;
    case (sel)
      PC_SEL_BRANCH:           npc = branch_tgt;
      PC_SEL_JUMP:             npc = jump_tgt;
      PC_SEL_SEQ, PC_SEL_RSVD: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - PC fetch stage; define MISALIGN_TRAP_EN to trap misaligned redirect targets
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] branch_tgt,
  input  logic [XLEN-1:0] jump_tgt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_err
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_d;
  logic [XLEN-1:0] hold_addr, hold_d;
  logic [XLEN-1:0] inst_out_q, inst_pc_q;
  logic [XLEN-1:0] pc_plus4, npc, target;
  logic            drop, drop_d;
  logic            capture;
  logic            take;
  logic [1:0]      mux_sel;

  assign take     = redirect_taken(redirect, pc_sel);
  assign pc_plus4 = pc + XLEN'(4);
  assign mux_sel  = take ? pc_sel : PC_SEL_SEQ;

  npc_sel_mux #(.XLEN(XLEN)) u_npc_sel_mux (
    .sel        (mux_sel),
    .pc_plus4   (pc_plus4),
    .branch_tgt (branch_tgt),
    .jump_tgt   (jump_tgt),
    .npc        (npc)
  );

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign target     = npc;
  assign misaligned = take && (npc[1:0] != 2'b00);
  assign fetch_err  = (state == ST_ERR);
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  assign target    = take ? (npc & ALIGN_MASK) : npc;
  assign fetch_err = 1'b0;
`endif

  // While a dropped request is still outstanding the old address stays on the bus
  assign imem_addr  = drop ? hold_addr : pc;
  assign inst_valid = (state == ST_HOLD);
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state, request strobe and datapath control
  always_comb begin
    state_next = state;
    pc_d       = pc;
    drop_d     = drop;
    hold_d     = hold_addr;
    capture    = 1'b0;
    imem_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
        if (take) pc_d = target;
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          drop_d = 1'b0;
          if (take) begin
            pc_d = target;
          end else if (!drop) begin
            capture    = 1'b1;
            pc_d       = target;
            state_next = ST_HOLD;
          end
        end else if (take) begin
          pc_d = target;
          if (!drop) begin
            drop_d = 1'b1;
            hold_d = pc;
          end
        end
      end
      ST_HOLD: begin
        if (take) begin
          pc_d       = target;
          state_next = ST_REQ;
        end else if (inst_ready) begin
          state_next = ST_REQ;
        end
      end
      default: begin
        state_next = state;
      end
    endcase
`ifdef MISALIGN_TRAP_EN
    if (misaligned && (state != ST_ERR)) begin
      state_next = ST_ERR;
      drop_d     = 1'b0;
    end
`endif
  end

  // PC, dropped-request tracking and decode-side registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      hold_addr  <= RESET_PC;
      drop       <= 1'b0;
      inst_out_q <= '0;
      inst_pc_q  <= '0;
    end else begin
      pc        <= pc_d;
      hold_addr <= hold_d;
      drop      <= drop_d;
      if (capture) begin
        inst_out_q <= imem_rdata;
        inst_pc_q  <= pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - directed plus randomized bench for pc_fetch_stage against a behavioural model
module tb_pc_fetch_stage;

  localparam logic [31:0] K = 32'hC0DE_0000;
  localparam int M_START = 0, M_FETCH = 1, M_SHOW = 2, M_TRAP = 3;

  logic        clk = 1'b0, reset = 1'b1, redirect = 1'b0, imem_ack = 1'b0, inst_ready = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] branch_tgt = '0, jump_tgt = '0, imem_rdata = '0;
  logic        imem_req, inst_valid, fetch_err;
  logic [31:0] imem_addr, inst_out, inst_pc;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;
  bit rand_mode = 1'b0;
  int lat = 2, wcnt = 0;

  always #5 clk = ~clk;

  pc_fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .pc_sel     (pc_sel),
    .branch_tgt (branch_tgt),
    .jump_tgt   (jump_tgt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .fetch_err  (fetch_err)
  );

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where the next fetch goes, whether a stale response is pending,
  // and what decode is currently being shown.
  int          m_mode = M_START;
  logic [31:0] m_pc = '0, m_stale = '0, m_out = '0, m_opc = '0;
  bit          m_discard = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    logic        taken, trap_now;
    logic [31:0] tgt;
    if (reset) begin
      m_mode = M_START; m_pc = '0; m_stale = '0; m_discard = 1'b0; m_out = '0; m_opc = '0;
    end else begin
      taken = redirect && (pc_sel == 2'b01 || pc_sel == 2'b10);
      tgt   = (pc_sel == 2'b01) ? branch_tgt : jump_tgt;
      trap_now = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_now = taken && (tgt[1:0] != 2'b00) && (m_mode != M_TRAP);
`else
      tgt = tgt & 32'hFFFF_FFFC;
`endif
      if (trap_now) begin
        m_mode = M_TRAP;
        m_discard = 1'b0;
      end else if (m_mode == M_START) begin
        if (taken) m_pc = tgt;
        m_mode = M_FETCH;
      end else if (m_mode == M_FETCH) begin
        if (imem_ack) begin
          if (taken) begin
            m_pc = tgt;
          end else if (!m_discard) begin
            m_out = imem_rdata; m_opc = m_pc; m_pc = m_pc + 32'd4; m_mode = M_SHOW;
          end
          m_discard = 1'b0;
        end else if (taken) begin
          if (!m_discard) begin m_stale = m_pc; m_discard = 1'b1; end
          m_pc = tgt;
        end
      end else if (m_mode == M_SHOW) begin
        if (taken) begin m_pc = tgt; m_mode = M_FETCH; end
        else if (inst_ready) m_mode = M_FETCH;
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("imem_req", imem_req, m_mode == M_FETCH);
      if (m_mode == M_FETCH || reset) check_word("imem_addr", imem_addr, m_discard ? m_stale : m_pc);
      check_bit("inst_valid", inst_valid, m_mode == M_SHOW);
      if (m_mode == M_SHOW || reset) begin
        check_word("inst_out", inst_out, m_out);
        check_word("inst_pc", inst_pc, m_opc);
      end
      check_bit("fetch_err", fetch_err, m_mode == M_TRAP);
    end
  end

  // Instruction memory responder: ack after lat cycles of request, stray acks in random mode
  always @(posedge clk) begin
    #1;
    if (imem_ack) begin
      imem_ack = 1'b0;
      wcnt = 0;
      if (rand_mode) lat = $urandom_range(0, 3);
    end
    if (reset) begin
      wcnt = 0;
    end else if (imem_req) begin
      if (wcnt == lat) begin
        imem_ack = 1'b1;
        imem_rdata = rand_mode ? $urandom : (imem_addr ^ K);
      end
      wcnt++;
    end else begin
      wcnt = 0;
      if (rand_mode && $urandom_range(0, 7) == 0) begin
        imem_ack = 1'b1;
        imem_rdata = $urandom;
      end
    end
  end

  function automatic logic [31:0] pick_target();
    logic [31:0] t = $urandom;
    int r = $urandom_range(0, 31);
    if (r == 0) return 32'hFFFF_FFFC;
`ifdef MISALIGN_TRAP_EN
    if (r == 1) return t | 32'h2;
`else
    if (r < 8) return t;
`endif
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic wait_for(input bit want_valid, input string name, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_valid ? inst_valid : imem_req) && n < max);
    if (!(want_valid ? inst_valid : imem_req)) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout %s: waited %0d cycles, signal still low", name, n);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("rst imem_req", imem_req, 1'b0);
    check_word("rst imem_addr", imem_addr, 32'h0);
    check_bit("rst inst_valid", inst_valid, 1'b0);
    check_word("rst inst_out", inst_out, 32'h0);
    check_word("rst inst_pc", inst_pc, 32'h0);
    check_bit("rst fetch_err", fetch_err, 1'b0);
    chk_en = 1'b1;
    @(posedge clk); #1 reset = 1'b0; inst_ready = 1'b1;

    // Sequential fetch 0x0, 0x4, 0x8
    wait_for(0, "req 0x0", 20);   check_word("seq addr0", imem_addr, 32'h0);
    wait_for(1, "valid 0x0", 20); check_word("seq pc0", inst_pc, 32'h0);
    check_word("seq out0", inst_out, 32'h0 ^ K);
    wait_for(0, "req 0x4", 20);   check_word("seq addr4", imem_addr, 32'h4);
    wait_for(1, "valid 0x4", 20); check_word("seq pc4", inst_pc, 32'h4);
    wait_for(0, "req 0x8", 20);   check_word("seq addr8", imem_addr, 32'h8);
    inst_ready = 1'b0;
    wait_for(1, "valid 0x8", 20); check_word("seq pc8", inst_pc, 32'h8);

    // Decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("stall valid", inst_valid, 1'b1);
      check_word("stall out", inst_out, 32'h8 ^ K);
      check_bit("stall req", imem_req, 1'b0);
    end

    // Jump redirect in HOLD together with inst_ready
    redirect = 1'b1; pc_sel = 2'b10; jump_tgt = 32'h40; inst_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0; inst_ready = 1'b0;
    check_bit("jump valid cleared", inst_valid, 1'b0);
    check_word("jump addr", imem_addr, 32'h40);

    // Branch redirect while the 0x40 request is outstanding
    redirect = 1'b1; pc_sel = 2'b01; branch_tgt = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    check_word("drop addr held", imem_addr, 32'h40);
    for (int i = 0; i < 10 && imem_addr == 32'h40 && !inst_valid; i++) @(negedge clk);
    check_word("drop next addr", imem_addr, 32'h100);
    wait_for(1, "valid 0x100", 20);
    check_word("drop first pc", inst_pc, 32'h100);
    check_word("drop first out", inst_out, 32'h100 ^ K);

    // Wrap at the top of the address space
    redirect = 1'b1; pc_sel = 2'b10; jump_tgt = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    check_word("wrap addr", imem_addr, 32'hFFFF_FFFC);
    wait_for(1, "valid top", 20);
    check_word("wrap pc", inst_pc, 32'hFFFF_FFFC);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check_word("wrap next addr", imem_addr, 32'h0);
    wait_for(1, "valid wrapped", 20);

    // Reserved and sequential pc_sel do not redirect
    redirect = 1'b1; pc_sel = 2'b11; jump_tgt = 32'h200; branch_tgt = 32'h300;
    @(negedge clk);
    check_bit("rsvd ignored", inst_valid, 1'b1);
    pc_sel = 2'b00;
    @(negedge clk);
    check_bit("seq sel ignored", inst_valid, 1'b1);
    check_word("ignored pc", inst_pc, 32'h0);

    // Misaligned target
    pc_sel = 2'b10; jump_tgt = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
`ifdef MISALIGN_TRAP_EN
    check_bit("trap err", fetch_err, 1'b1);
    check_bit("trap valid", inst_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("trap no req", imem_req, 1'b0);
    end
`else
    check_bit("align req", imem_req, 1'b1);
    check_word("align addr", imem_addr, 32'h100);
    check_bit("align no err", fetch_err, 1'b0);
`endif

    // Asynchronous reset between clock edges
    #2 reset = 1'b1;
    #1;
    check_bit("async req", imem_req, 1'b0);
    check_word("async addr", imem_addr, 32'h0);
    check_bit("async err", fetch_err, 1'b0);
    check_bit("async valid", inst_valid, 1'b0);

    // Randomized traffic
    rand_mode = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      redirect   = ($urandom_range(0, 5) == 0);
      pc_sel     = 2'($urandom_range(0, 3));
      branch_tgt = pick_target();
      jump_tgt   = pick_target();
      inst_ready = ($urandom_range(0, 9) < 6);
      if (reset) reset = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
      else if ($urandom_range(0, 249) == 0) reset = 1'b1;
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
